// File: rtl/uart_rx_if.sv
// Receive-side output bundle of the UART receiver: received byte plus status strobes.
// The receiver drives it through the master modport and the consumer reads it through the slave modport.
interface uart_rx_if;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_busy;
    logic       o_frame_err;

    modport master (output o_data, o_valid, o_busy, o_frame_err);
    modport slave  (input  o_data, o_valid, o_busy, o_frame_err);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling driven by a down-counting baud timer.
// state | meaning
// IDLE  | waiting for the line to go low
// START | timing to mid start bit and rejecting glitches
// DATA  | sampling 8 data bits, LSB first
// STOP  | sampling the stop bit and then delivering the byte or flagging a framing error
// BREAK | line held low after a bad stop bit, waiting for it to return high
module uart_rx #(
    parameter int CLKS_PER_BAUD = 1563
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_uart_rx,
    uart_rx_if.master  rx_if
);
    localparam int HALF  = CLKS_PER_BAUD / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BAUD);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BAUD_LOAD = CNT_W'(CLKS_PER_BAUD - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             rx_meta, rx_s;
    logic             tick;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_uart_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign tick = (cnt_q == '0);

    // Every sample point reloads the full bit period, so sample positions never accumulate drift.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = HALF_LOAD;
                end
            end
            START: begin
                if (!tick) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (rx_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = DATA;
                    bit_d   = '0;
                    cnt_d   = BAUD_LOAD;
                end
            end
            DATA: begin
                if (!tick) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    shift_d[bit_q] = rx_s;
                    cnt_d          = BAUD_LOAD;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (!tick) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (rx_s) begin
                    data_d  = shift_q;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    ferr_d  = 1'b1;
                    state_d = BREAK;
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_if.o_data      = data_q;
    assign rx_if.o_valid     = valid_q;
    assign rx_if.o_frame_err = ferr_q;
    assign rx_if.o_busy      = (state_q != IDLE);
endmodule
